need_scheduler: RTL and testbench

Owns the four need levels (salud, energia, hambre, diversion) of the pet and sequences every change to them. A prescaler produces the game tick. On each tick a 4-slot sequencer visits each need in turn and applies one combined update per slot: button credit, decay and test-mode override. Outputs feed the face/7-segment display logic. Buttons arrive already synchronised and debounced.

---
 rtl/need_pkg.sv | 40 ++++
 rtl/need_tick_prescaler.sv | 28 ++
 rtl/need_scheduler.sv | 167 ++++++++++++++++
 tb/tb_need_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/need_pkg.sv
// Shared types and constants for the pet need scheduler.
// Includes a 7-segment table used by the display blocks.
package need_pkg;

  localparam int LEVEL_W = 4;

  localparam logic [1:0] NEED_SALUD     = 2'd0;
  localparam logic [1:0] NEED_ENERGIA   = 2'd1;
  localparam logic [1:0] NEED_HAMBRE    = 2'd2;
  localparam logic [1:0] NEED_DIVERSION = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_S0,
    ST_S1,
    ST_S2,
    ST_S3
  } state_t;

  // Segments {g,f,e,d,c,b,a}, active high.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'd0:    s = 7'h3f;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5b;
      4'd3:    s = 7'h4f;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6d;
      4'd6:    s = 7'h7d;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7f;
      4'd9:    s = 7'h6f;
      4'd10:   s = 7'h77;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/need_tick_prescaler.sv
// Game-tick prescaler: one-cycle pulse every TICK_DIV clocks.
// The pulse is decoded from the terminal count.
module need_tick_prescaler #(
  parameter int TICK_DIV = 7500000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/need_scheduler.sv
// Need level owner: each game tick walks four slots, one per need,
// applying button credit, decay and the test-mode override.
module need_scheduler
  import need_pkg::*;
#(
  parameter int TICK_DIV        = 7500000,
  parameter int DECAY_SALUD     = 20,
  parameter int DECAY_ENERGIA   = 15,
  parameter int DECAY_HAMBRE    = 10,
  parameter int DECAY_DIVERSION = 8,
  parameter int HOLD_TICKS      = 6,
  parameter int LEVEL_INIT      = 8,
  parameter int LEVEL_MAX       = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_salud,
  input  logic        btn_energia,
  input  logic        btn_hambre,
  input  logic        btn_diversion,
  input  logic        btn_test,
  output logic [15:0] levels,
  output logic [1:0]  sel,
  output logic        happy,
  output logic        test_mode,
  output logic        tick,
  output logic        busy
);

  state_t state, state_n;

  logic [LEVEL_W-1:0] lv [4];
  logic [7:0] dec [4];
  logic [7:0] dec_n [4];
  logic [7:0] hold_e, hold_d, hold_e_n, hold_d_n;
  logic pend_s, pend_h, prev_s, prev_h;
  logic [1:0] k;
  logic credit, expire, held;
  logic [7:0] dmax;
  logic [LEVEL_W-1:0] nxt;

  function automatic logic [LEVEL_W-1:0] upd(
    input logic [LEVEL_W-1:0] cur,
    input logic cr,
    input logic ex,
    input logic tm
  );
    logic signed [4:0] s;
    if (tm) begin
      if (!cr) return cur;
      return (cur == 4'd1) ? LEVEL_W'(LEVEL_MAX) : 4'd1;
    end
    s = $signed({1'b0, cur}) + $signed({4'b0, cr})
      - $signed({4'b0, ex});
    if (s < 5'sd0) return '0;
    if (s > $signed(5'(LEVEL_MAX))) return LEVEL_W'(LEVEL_MAX);
    return s[3:0];
  endfunction

  need_tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_pre (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign busy   = (state != ST_IDLE);
  assign levels = {lv[3], lv[2], lv[1], lv[0]};

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (tick) state_n = ST_S0;
      ST_S0:   state_n = ST_S1;
      ST_S1:   state_n = ST_S2;
      ST_S2:   state_n = ST_S3;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    k        = NEED_SALUD;
    dmax     = 8'(DECAY_SALUD);
    credit   = 1'b0;
    expire   = 1'b0;
    hold_e_n = hold_e;
    hold_d_n = hold_d;
    dec_n    = dec;
    unique case (1'b1)
      state == ST_S0: begin
        k      = NEED_SALUD;
        dmax   = 8'(DECAY_SALUD);
        credit = pend_s;
      end
      state == ST_S1: begin
        k    = NEED_ENERGIA;
        dmax = 8'(DECAY_ENERGIA);
        hold_e_n = btn_energia ? hold_e + 8'd1 : 8'd0;
        if (hold_e_n == 8'(HOLD_TICKS)) begin
          credit   = 1'b1;
          hold_e_n = '0;
        end
      end
      state == ST_S2: begin
        k      = NEED_HAMBRE;
        dmax   = 8'(DECAY_HAMBRE);
        credit = pend_h;
      end
      state == ST_S3: begin
        k    = NEED_DIVERSION;
        dmax = 8'(DECAY_DIVERSION);
        hold_d_n = btn_diversion ? hold_d + 8'd1 : 8'd0;
        if (hold_d_n == 8'(HOLD_TICKS)) begin
          credit   = 1'b1;
          hold_d_n = '0;
        end
      end
      default: ;
    endcase
    // Sleeping freezes the energia decay count.
    held = (state == ST_S1) && btn_energia;
    if (busy && !test_mode && !held) begin
      dec_n[k] = dec[k] + 8'd1;
      if (dec_n[k] == dmax) begin
        expire   = 1'b1;
        dec_n[k] = '0;
      end
    end
    nxt = upd(lv[k], credit, expire, test_mode);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sel       <= NEED_SALUD;
      happy     <= 1'b1;
      test_mode <= 1'b0;
      pend_s    <= 1'b0;
      pend_h    <= 1'b0;
      prev_s    <= 1'b0;
      prev_h    <= 1'b0;
      hold_e    <= '0;
      hold_d    <= '0;
      for (int i = 0; i < 4; i++) begin
        lv[i]  <= LEVEL_W'(LEVEL_INIT);
        dec[i] <= '0;
      end
    end else begin
      state     <= state_n;
      test_mode <= test_mode | btn_test;
      prev_s    <= btn_salud;
      prev_h    <= btn_hambre;
      pend_s    <= (btn_salud & ~prev_s)
                 | (pend_s & (state != ST_S0));
      pend_h    <= (btn_hambre & ~prev_h)
                 | (pend_h & (state != ST_S2));
      hold_e    <= hold_e_n;
      hold_d    <= hold_d_n;
      dec       <= dec_n;
      if (busy) lv[k] <= nxt;
      if (credit) sel <= k;
      happy <= (lv[sel] >= 4'd5);
    end
  end

endmodule

// File: tb/tb_need_scheduler.sv
// Bench for need_scheduler: tick-level need model checked every cycle,
// plus directed scenarios with hand-computed level snapshots.
module tb_need_scheduler;

  localparam int TD   = 6;
  localparam int HOLD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_salud = 1'b0, btn_energia = 1'b0, btn_hambre = 1'b0;
  logic btn_diversion = 1'b0, btn_test = 1'b0;
  logic [15:0] levels;
  logic [1:0] sel;
  logic happy, test_mode, tick, busy;

  int compared = 0;
  int mismatched = 0;

  need_scheduler #(
    .TICK_DIV(TD),
    .DECAY_HAMBRE(3),
    .HOLD_TICKS(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_salud(btn_salud), .btn_energia(btn_energia),
    .btn_hambre(btn_hambre), .btn_diversion(btn_diversion),
    .btn_test(btn_test),
    .levels(levels), .sel(sel), .happy(happy),
    .test_mode(test_mode), .tick(tick), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: m_slot is the need being serviced this cycle (-1 = none),
  // m_phase counts clocks within the game-tick period.
  int m_lv[4];
  int m_dec[4];
  int m_hold[4];
  bit m_pend[4];
  int decay_of[4] = '{20, 15, 3, 8};
  int m_sel, m_phase, m_slot;
  bit m_happy, m_test, m_ps, m_ph;
  bit cr, ex, hp;
  int nk;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_lv[i] = 8; m_dec[i] = 0; m_hold[i] = 0; m_pend[i] = 0;
      end
      m_sel = 0; m_happy = 1; m_test = 0;
      m_phase = 0; m_slot = -1; m_ps = 0; m_ph = 0;
    end else begin
      hp = (m_lv[m_sel] >= 5);
      if (m_slot >= 0) begin
        nk = m_slot; cr = 0; ex = 0;
        if (nk == 0 || nk == 2) begin
          cr = m_pend[nk];
          m_pend[nk] = 0;
        end else if ((nk == 1 && btn_energia) || (nk == 3 && btn_diversion)) begin
          m_hold[nk]++;
          if (m_hold[nk] == HOLD) begin cr = 1; m_hold[nk] = 0; end
        end else begin
          m_hold[nk] = 0;
        end
        if (!m_test && !(nk == 1 && btn_energia)) begin
          m_dec[nk]++;
          if (m_dec[nk] == decay_of[nk]) begin ex = 1; m_dec[nk] = 0; end
        end
        if (m_test) begin
          if (cr) m_lv[nk] = (m_lv[nk] == 1) ? 10 : 1;
        end else begin
          m_lv[nk] = m_lv[nk] + int'(cr) - int'(ex);
          if (m_lv[nk] < 0) m_lv[nk] = 0;
          if (m_lv[nk] > 10) m_lv[nk] = 10;
        end
        if (cr) m_sel = nk;
      end
      if (btn_salud && !m_ps) m_pend[0] = 1;
      if (btn_hambre && !m_ph) m_pend[2] = 1;
      m_ps = btn_salud; m_ph = btn_hambre;
      m_happy = hp;
      m_test = m_test | btn_test;
      if (m_phase == TD - 1) begin
        m_phase = 0; m_slot = 0;
      end else begin
        m_phase++;
        m_slot = (m_slot >= 0 && m_slot < 3) ? m_slot + 1 : -1;
      end
    end
  end

  logic [21:0] got, expv;
  always @(posedge clk) begin
    #1;
    got = {levels, sel, happy, test_mode, tick, busy};
    expv = {m_lv[3][3:0], m_lv[2][3:0], m_lv[1][3:0], m_lv[0][3:0],
            m_sel[1:0], m_happy, m_test,
            (m_phase == TD - 1), (m_slot >= 0)};
    compared++;
    if (got !== expv) begin
      mismatched++;
      $display("FAIL cycle t=%0t got=%h expected=%h", $time, got, expv);
    end
  end

  task automatic chk(input string name, input logic [31:0] g, input logic [31:0] e);
    compared++;
    if (g !== e) begin
      mismatched++;
      $display("FAIL %s got=%h expected=%h", name, g, e);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    btn_salud = 0; btn_energia = 0; btn_hambre = 0;
    btn_diversion = 0; btn_test = 0;
    rst_n = 0;
    cycles(2);
    rst_n = 1;
  endtask

  task automatic pulse_salud();
    btn_salud = 1; cycles(1); btn_salud = 0;
  endtask

  task automatic pulse_hambre();
    btn_hambre = 1; cycles(1); btn_hambre = 0;
  endtask

  initial begin
    int nb, n;

    // Idle: hambre decays on the 3rd tick.
    do_reset();
    chk("reset_levels", 32'(levels), 32'h8888);
    cycles(24);
    chk("idle_decay", 32'(levels), 32'h8788);
    nb = 0;
    for (int i = 0; i < TD; i++) begin
      cycles(1);
      if (busy) nb++;
    end
    chk("busy_per_tick", nb, 4);

    // Credit and decay cancel on hambre.
    do_reset();
    cycles(14);
    pulse_hambre();
    cycles(9);
    chk("cancel_levels", 32'(levels), 32'h8888);
    chk("cancel_sel", 32'(sel), 32'd2);
    chk("cancel_happy", 32'(happy), 32'd1);

    // Held energia saturates at 10.
    do_reset();
    btn_energia = 1;
    cycles(42);
    chk("hold_levels", 32'(levels), 32'h86A8);
    chk("hold_sel", 32'(sel), 32'd1);
    btn_energia = 0;

    // Two salud edges in one interval give one credit.
    do_reset();
    cycles(1);
    pulse_salud();
    cycles(1);
    pulse_salud();
    cycles(8);
    chk("dbl_salud", 32'(levels), 32'h8889);

    // Decay floors at zero; low hambre makes the pet unhappy.
    do_reset();
    cycles(220);
    chk("floor_levels", 32'(levels), 32'h4067);
    pulse_hambre();
    cycles(7);
    chk("floor_credit", 32'(levels), 32'h4167);
    chk("floor_sel", 32'(sel), 32'd2);
    chk("floor_happy", 32'(happy), 32'd0);

    // Test mode toggles salud between 1 and 10, no decay.
    do_reset();
    cycles(1);
    btn_test = 1; cycles(1); btn_test = 0;
    pulse_salud();
    cycles(7);
    chk("test_one", 32'(levels), 32'h8881);
    chk("test_mode", 32'(test_mode), 32'd1);
    chk("test_happy", 32'(happy), 32'd0);
    pulse_salud();
    cycles(150);
    chk("test_ten", 32'(levels), 32'h888A);

    // Reset asserted in S1.
    n = 0;
    @(negedge clk);
    while (!tick && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("tick_seen", 32'(tick), 32'd1);
    cycles(2);
    chk("in_slot", 32'(busy), 32'd1);
    rst_n = 0;
    cycles(1);
    chk("rst_levels", 32'(levels), 32'h8888);
    chk("rst_flags", {28'd0, sel, happy, test_mode},
        {28'd0, 2'd0, 1'b1, 1'b0});
    chk("rst_busy", {30'd0, tick, busy}, 32'd0);
    rst_n = 1;
    cycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
